// File: rtl/image_bmp_writer_if.sv
// Pixel-in / BMP-byte-out bundle for image_bmp_writer.
// Byte handshake: a byte moves when byte_valid & byte_ready are both high at a
// rising clock edge; while byte_valid is high and byte_ready is low, byte_out
// holds steady, and byte_valid stays high until the last byte of the file has
// moved.
interface image_bmp_writer_if;
    logic       HSYNC;
    logic [7:0] DATA_R;
    logic [7:0] DATA_G;
    logic [7:0] DATA_B;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_done;
    logic [2:0] fsm_state;

    // Upstream pixel source plus downstream byte sink.
    modport master (
        output HSYNC, DATA_R, DATA_G, DATA_B, byte_ready,
        input  byte_out, byte_valid, frame_done, fsm_state
    );

    // The writer itself.
    modport slave (
        input  HSYNC, DATA_R, DATA_G, DATA_B, byte_ready,
        output byte_out, byte_valid, frame_done, fsm_state
    );
endinterface

// File: rtl/image_bmp_writer.sv
// Captures one frame of RTL888 pixels into a buffer, then streams it out as a
// 24-bit bottom-up BMP file (54-byte header + 4-byte-padded BGR rows).
module image_bmp_writer #(
    parameter int WIDTH  = 300,
    parameter int HEIGHT = 400
) (
    input logic               HCLK,
    input logic               HRESETn,
    image_bmp_writer_if.slave bus
);
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int ROWB   = ((WIDTH * 3 + 3) / 4) * 4;
    localparam int IMGSZ  = ROWB * HEIGHT;
    localparam int FILESZ = 54 + IMGSZ;
    localparam int PAD    = ROWB - 3 * WIDTH;
    localparam int AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BW     = $clog2(FILESZ);
    localparam int CW     = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HEADER  = 3'd2,
        ST_BODY    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t          state;
    logic [AW-1:0]   pix_cnt;
    logic [BW-1:0]   byte_idx;
    logic [AW-1:0]   rd_addr;
    logic [23:0]     rd_data;
    logic [23:0]     pix_q;
    logic [CW-1:0]   col;       // col == WIDTH means "in row padding"
    logic [1:0]      comp;      // 0=B, 1=G, 2=R of pixel at col
    logic [1:0]      pad_cnt;
    logic [7:0]      byte_q;
    logic            valid_q;
    logic            done_q;

    logic [23:0]     mem [NPIX];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            fire;

    logic [7:0]      nb_byte;
    logic [CW-1:0]   nb_col;
    logic [1:0]      nb_comp;
    logic [1:0]      nb_pad;
    logic [AW-1:0]   nb_addr;
    logic [23:0]     nb_pix;

    assign fire          = valid_q && bus.byte_ready;
    assign wr_en         = HRESETn && bus.HSYNC && (state == ST_IDLE || state == ST_CAPTURE);
    assign wr_addr       = (state == ST_IDLE) ? '0 : pix_cnt;
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.frame_done = done_q;
    assign bus.fsm_state  = state;

    // Header byte at file offset idx; all multi-byte fields little-endian.
    function automatic logic [7:0] hdr_byte(input int idx);
        logic [31:0] v;
        int          base;
        v    = '0;
        base = idx;
        if (idx == 0) return 8'h42;
        if (idx == 1) return 8'h4D;
        if      (idx >= 2  && idx <= 5)  begin v = 32'(FILESZ); base = 2;  end
        else if (idx >= 10 && idx <= 13) begin v = 32'd54;      base = 10; end
        else if (idx >= 14 && idx <= 17) begin v = 32'd40;      base = 14; end
        else if (idx >= 18 && idx <= 21) begin v = 32'(WIDTH);  base = 18; end
        else if (idx >= 22 && idx <= 25) begin v = 32'(HEIGHT); base = 22; end
        else if (idx >= 26 && idx <= 27) begin v = 32'd1;       base = 26; end
        else if (idx >= 28 && idx <= 29) begin v = 32'd24;      base = 28; end
        else if (idx >= 34 && idx <= 37) begin v = 32'(IMGSZ);  base = 34; end
        return 8'(v >> (8 * (idx - base)));
    endfunction

    // Frame buffer: write on captured pixels, synchronous read of the prefetch address.
    always_ff @(posedge HCLK) begin
        if (wr_en) mem[wr_addr] <= {bus.DATA_R, bus.DATA_G, bus.DATA_B};
        rd_data <= mem[rd_addr];
    end

    // Next body byte and advanced row/col/component/pad counters.
    // rd_data always holds the next pixel to emit; on its B byte it is latched
    // into pix_q and the read address moves on, leaving >= 3 cycles to refill.
    always_comb begin
        nb_byte = 8'h00;
        nb_col  = col;
        nb_comp = comp;
        nb_pad  = pad_cnt;
        nb_addr = rd_addr;
        nb_pix  = pix_q;
        if (int'(col) < WIDTH) begin
            case (comp)
                2'd0: begin
                    nb_byte = rd_data[7:0];
                    nb_pix  = rd_data;
                    nb_comp = 2'd1;
                    if (int'(col) == WIDTH - 1) begin
                        // Jump to the start of the row above (rows go bottom-up).
                        if (int'(rd_addr) >= 2 * WIDTH - 1)
                            nb_addr = rd_addr - AW'(2 * WIDTH - 1);
                        else
                            nb_addr = '0;
                    end else begin
                        nb_addr = rd_addr + AW'(1);
                    end
                end
                2'd1: begin
                    nb_byte = pix_q[15:8];
                    nb_comp = 2'd2;
                end
                default: begin
                    nb_byte = pix_q[23:16];
                    nb_comp = 2'd0;
                    if (int'(col) == WIDTH - 1)
                        nb_col = (PAD == 0) ? '0 : CW'(WIDTH);
                    else
                        nb_col = col + CW'(1);
                end
            endcase
        end else begin
            if (int'(pad_cnt) == PAD - 1) begin
                nb_pad = 2'd0;
                nb_col = '0;
            end else begin
                nb_pad = pad_cnt + 2'd1;
            end
        end
    end

    // Main FSM: capture, header, body, done pulse; all outputs registered.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            pix_cnt  <= '0;
            byte_idx <= '0;
            rd_addr  <= '0;
            pix_q    <= '0;
            col      <= '0;
            comp     <= '0;
            pad_cnt  <= '0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_CAPTURE: begin
                    if (bus.HSYNC) begin
                        if (wr_addr == AW'(NPIX - 1)) begin
                            state    <= ST_HEADER;
                            pix_cnt  <= '0;
                            byte_idx <= '0;
                            byte_q   <= 8'h42;
                            valid_q  <= 1'b1;
                            rd_addr  <= AW'((HEIGHT - 1) * WIDTH);
                            col      <= '0;
                            comp     <= '0;
                            pad_cnt  <= '0;
                        end else begin
                            state   <= ST_CAPTURE;
                            pix_cnt <= wr_addr + AW'(1);
                        end
                    end
                end
                ST_HEADER: begin
                    if (fire) begin
                        byte_idx <= byte_idx + BW'(1);
                        if (byte_idx == BW'(53)) begin
                            state   <= ST_BODY;
                            byte_q  <= nb_byte;
                            col     <= nb_col;
                            comp    <= nb_comp;
                            pad_cnt <= nb_pad;
                            rd_addr <= nb_addr;
                            pix_q   <= nb_pix;
                        end else begin
                            byte_q <= hdr_byte(int'(byte_idx) + 1);
                        end
                    end
                end
                ST_BODY: begin
                    if (fire) begin
                        if (int'(byte_idx) == FILESZ - 1) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                            byte_q   <= nb_byte;
                            col      <= nb_col;
                            comp     <= nb_comp;
                            pad_cnt  <= nb_pad;
                            rd_addr  <= nb_addr;
                            pix_q    <= nb_pix;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    byte_idx <= '0;
                    pix_cnt  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_bmp_writer.sv
// Bench for image_bmp_writer with a 3x2 image (ROWB=12, IMGSZ=24, FILESZ=78).
module tb_image_bmp_writer;
    localparam int W      = 3;
    localparam int H      = 2;
    localparam int ROWB   = ((W * 3 + 3) / 4) * 4;
    localparam int IMGSZ  = ROWB * H;
    localparam int FILESZ = 54 + IMGSZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    image_bmp_writer_if bus ();

    image_bmp_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got [0:127];
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    logic       hold_pending = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    int lit_idx [0:25] = '{0, 1, 2, 3, 4, 5, 10, 18, 22, 26, 28, 34,
                           54, 55, 56, 57, 58, 59, 60, 61, 62, 63, 64, 65, 66, 77};
    int lit_val [0:25] = '{8'h42, 8'h4D, 8'h4E, 0, 0, 0, 8'h36, 8'h03, 8'h02, 8'h01, 8'h18, 8'h18,
                           8'h23, 8'h13, 8'h03, 8'h24, 8'h14, 8'h04, 8'h25, 8'h15, 8'h05,
                           0, 0, 0, 8'h20, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: the whole file as a byte queue, built from the BMP layout rules.
    task automatic push_le(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endtask

    task automatic build_model();
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(FILESZ, 4); push_le(0, 4); push_le(54, 4); push_le(40, 4);
        push_le(W, 4); push_le(H, 4); push_le(1, 2); push_le(24, 2);
        push_le(0, 4); push_le(IMGSZ, 4); push_le(0, 16);
        for (int r = H - 1; r >= 0; r--) begin
            for (int c = 0; c < W; c++) begin
                exp_q.push_back(8'(8'h20 + r * W + c));
                exp_q.push_back(8'(8'h10 + r * W + c));
                exp_q.push_back(8'(r * W + c));
            end
            for (int p = 0; p < ROWB - 3 * W; p++) exp_q.push_back(8'h00);
        end
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    // Scoreboard: every transfer against the model, plus hold-while-stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", int'(bus.byte_valid), 1);
                check("hold_byte", int'(bus.byte_out), int'(hold_byte));
            end
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_byte[%0d]", xfer_cnt), int'(bus.byte_out), -1);
                end else begin
                    check($sformatf("stream_byte[%0d]", xfer_cnt), int'(bus.byte_out), int'(exp_q.pop_front()));
                end
                if (xfer_cnt < 128) got[xfer_cnt] = bus.byte_out;
                xfer_cnt++;
            end
            hold_pending = bus.byte_valid && !bus.byte_ready;
            hold_byte    = bus.byte_out;
            if (bus.frame_done) done_cnt++;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < W * H; k++) begin
            bus.HSYNC  = 1'b1;
            bus.DATA_R = 8'(k);
            bus.DATA_G = 8'(8'h10 + k);
            bus.DATA_B = 8'(8'h20 + k);
            if (k == W * H - 1) check("valid_before_last_pixel", int'(bus.byte_valid), 0);
            tick();
            bus.HSYNC  = 1'b0;
            bus.DATA_R = 8'($urandom_range(0, 255));
            if (k < W * H - 1)
                for (int g = 0; g < gap; g++) tick();
        end
        check("latency_valid", int'(bus.byte_valid), 1);
        check("latency_byte0", int'(bus.byte_out), 8'h42);
    endtask

    task automatic wait_xfer(input int n);
        int cyc = 0;
        while (xfer_cnt != n && cyc < 500) begin
            tick();
            cyc++;
        end
        check($sformatf("reach_xfer_%0d", n), xfer_cnt, n);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!bus.frame_done && cyc < 500) begin
            tick();
            cyc++;
        end
        check("frame_done_seen", int'(bus.frame_done), 1);
        check("done_valid_low", int'(bus.byte_valid), 0);
        check("transfer_count", xfer_cnt, FILESZ);
        check("model_drained", exp_q.size(), 0);
        tick();
        check("frame_done_one_cycle", int'(bus.frame_done), 0);
        check("done_pulse_count", done_cnt, 1);
        check("back_to_idle", int'(bus.fsm_state), 0);
    endtask

    task automatic check_literals(input string tag);
        for (int i = 0; i < 26; i++)
            check($sformatf("%s_lit[%0d]", tag, lit_idx[i]), int'(got[lit_idx[i]]), lit_val[i]);
    endtask

    initial begin
        bus.HSYNC      = 1'b0;
        bus.DATA_R     = 8'h00;
        bus.DATA_G     = 8'h00;
        bus.DATA_B     = 8'h00;
        bus.byte_ready = 1'b1;
        rst_n          = 1'b0;

        // 1. Reset with HSYNC noise
        for (int i = 0; i < 3; i++) begin
            bus.HSYNC  = 1'($urandom_range(0, 1));
            bus.DATA_R = 8'($urandom_range(0, 255));
            bus.DATA_G = 8'($urandom_range(0, 255));
            bus.DATA_B = 8'($urandom_range(0, 255));
            tick();
        end
        check("reset_byte_out", int'(bus.byte_out), 0);
        check("reset_valid", int'(bus.byte_valid), 0);
        check("reset_done", int'(bus.frame_done), 0);
        check("reset_state", int'(bus.fsm_state), 0);
        bus.HSYNC = 1'b0;
        rst_n     = 1'b1;
        tick();
        tick();
        check("post_reset_state", int'(bus.fsm_state), 0);
        check("post_reset_valid", int'(bus.byte_valid), 0);

        // 2/3. Back-to-back frame, ready always high
        build_model();
        send_frame(0);
        wait_done();
        check_literals("b2b");

        // 4. Gaps between pixels
        build_model();
        send_frame(1);
        wait_done();
        check_literals("gap");

        // 5. Backpressure while byte 10 is presented
        build_model();
        send_frame(0);
        wait_xfer(10);
        bus.byte_ready = 1'b0;
        check("stall_byte10", int'(bus.byte_out), 8'h36);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_byte_held", int'(bus.byte_out), 8'h36);
            check("stall_valid_held", int'(bus.byte_valid), 1);
        end
        bus.byte_ready = 1'b1;
        tick();
        check("after_stall_count", xfer_cnt, 11);
        check("after_stall_byte11", int'(bus.byte_out), 8'h00);
        wait_done();

        // 6. Reset in the middle of the header, then a fresh frame
        build_model();
        send_frame(0);
        wait_xfer(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_valid", int'(bus.byte_valid), 0);
        check("midreset_state", int'(bus.fsm_state), 0);
        check("midreset_byte", int'(bus.byte_out), 0);
        build_model();
        send_frame(0);
        wait_done();
        check_literals("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
